mips_tlb: RTL and testbench

- Fully associative joint TLB that sits directly beside the CP0/interrupt unit.
- Inputs: CP0's Index, EntryHi, EntryLo0, EntryLo1 and PageMask registers plus its tlbw strobe. Outputs: the 90-bit entry consumed by TLBR and the probe result consumed by TLBP.
- Translates the fetch and data virtual addresses with one-cycle registered latency.
- Produces the refill, invalid and modified flags that the pipeline turns into CP0's TLBL_i, TLBL_d, TLBS and MOD exception inputs.

---
 rtl/mips_tlb_pkg.sv | 40 ++++
 rtl/mips_tlb_match_port.sv | 63 ++++++
 rtl/mips_tlb.sv | 166 ++++++++++++++++
 tb/tb_mips_tlb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_tlb_pkg.sv
// Entry layout, segment constants and match helpers for the MIPS joint TLB.
package mips_tlb_pkg;

    localparam int ENTRY_W = 90;
    localparam int VPN2_HI = 89;
    localparam int VPN2_LO = VPN2_HI - 18;
    localparam int ASID_LO = 63;
    localparam int PM_LO   = 51;
    localparam int G_BIT   = 50;
    localparam int PFN0_LO = 30;
    localparam int PFN1_LO = 5;
    // Each half is {PFN[19:0], C[2:0], D, V}; the C/D/V bits sit just below the PFN.
    localparam int LO_W    = 25;
    localparam int LO0_LO  = PFN0_LO - 5;
    localparam int LO1_LO  = PFN1_LO - 5;

    localparam logic [1:0] UNMAPPED_SEG = 2'b10;

    function automatic logic [11:0] pm_legalize(input logic [11:0] pm);
        case (pm)
            12'h000, 12'h003, 12'h00F, 12'h03F,
            12'h0FF, 12'h3FF, 12'hFFF: return pm;
            default:                   return 12'h000;
        endcase
    endfunction

    function automatic logic entry_match(
        input logic [18:0] vpn2_e,
        input logic [7:0]  asid_e,
        input logic        g_e,
        input logic [11:0] pm_e,
        input logic [18:0] vpn2,
        input logic [7:0]  asid
    );
        logic [18:0] keep;
        keep = ~{7'b0, pm_legalize(pm_e)};
        return ((vpn2_e & keep) == (vpn2 & keep)) && (g_e || (asid_e == asid));
    endfunction

endpackage

// File: rtl/mips_tlb_match_port.sv
// One combinational lookup across every TLB entry; lowest matching index wins.
module tlb_match_port
    import mips_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 32,
    parameter int IDX_W       = 5
) (
    input  logic [TLB_ENTRIES-1:0][ENTRY_W-1:0] entries,
    input  logic [31:0]                          vaddr,
    input  logic [7:0]                           asid,
    input  logic                                 wr,
    output logic                                 hit,
    output logic [IDX_W-1:0]                     idx,
    output logic [31:0]                          paddr,
    output logic                                 v,
    output logic                                 d,
    output logic                                 mod
);

    logic [11:0]     sel_pm;
    logic [LO_W-1:0] sel_lo0;
    logic [LO_W-1:0] sel_lo1;
    logic [LO_W-1:0] lo;
    logic [11:0]     pm_eff;
    logic [12:0]     odd_onehot;
    logic [31:0]     off_mask;
    logic [2:0]      unused_cache;

    // Scan downward so the lowest-numbered hit is the last one assigned.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        sel_pm  = '0;
        sel_lo0 = '0;
        sel_lo1 = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (entry_match(entries[i][VPN2_LO +: 19], entries[i][ASID_LO +: 8],
                            entries[i][G_BIT], entries[i][PM_LO +: 12],
                            vaddr[31:13], asid)) begin
                hit     = 1'b1;
                idx     = IDX_W'(i);
                sel_pm  = entries[i][PM_LO +: 12];
                sel_lo0 = entries[i][LO0_LO +: LO_W];
                sel_lo1 = entries[i][LO1_LO +: LO_W];
            end
        end
    end

    // Page size picks the even/odd select bit and how many VA bits pass through.
    always_comb begin
        pm_eff     = pm_legalize(sel_pm);
        odd_onehot = {pm_eff, 1'b1} ^ {1'b0, pm_eff};
        lo         = (|(vaddr[24:12] & odd_onehot)) ? sel_lo1 : sel_lo0;
        off_mask   = {8'b0, pm_eff, 12'hFFF};
        v          = hit & lo[0];
        d          = hit & lo[1];
        mod        = hit & lo[0] & ~lo[1] & wr;
        paddr      = hit ? (({lo[24:5], 12'b0} & ~off_mask) | (vaddr & off_mask)) : 32'b0;
    end

    assign unused_cache = lo[4:2];

endmodule

// File: rtl/mips_tlb.sv
// Fully associative joint TLB: CP0 write/read/probe plus registered fetch and data translation.
module mips_tlb
    import mips_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 32,
    parameter int IDX_W       = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tlbw,
    input  logic [31:0]        index,
    input  logic [31:0]        entry_hi,
    input  logic [31:0]        entry_lo0,
    input  logic [31:0]        entry_lo1,
    input  logic [31:0]        mask,
    output logic [ENTRY_W-1:0] tlb_entry,
    input  logic               probe_req,
    output logic               probe_done,
    output logic [31:0]        entry_index,
    input  logic               inst_req,
    input  logic [31:0]        inst_vaddr,
    output logic               inst_valid,
    output logic [31:0]        inst_paddr,
    output logic               inst_refill,
    output logic               inst_invalid,
    input  logic               data_req,
    input  logic [31:0]        data_vaddr,
    input  logic               data_wr,
    output logic               data_valid,
    output logic [31:0]        data_paddr,
    output logic               data_refill,
    output logic               data_invalid,
    output logic               data_mod
);

    logic [TLB_ENTRIES-1:0][ENTRY_W-1:0] entries;

    logic             i_hit, i_v;
    logic [31:0]      i_paddr;
    logic             d_hit, d_v, d_mod;
    logic [31:0]      d_paddr;
    logic             p_hit;
    logic [IDX_W-1:0] p_idx;

    logic [IDX_W-1:0] unused_inst_idx, unused_data_idx;
    logic             unused_inst_d, unused_inst_mod, unused_data_d;
    logic [31:0]      unused_probe_paddr;
    logic             unused_probe_v, unused_probe_d, unused_probe_mod;
    logic             unused_bits;

    // Global bit is the AND of both halves, as on real MIPS hardware.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entries <= '0;
        end else if (tlbw) begin
            entries[index[IDX_W-1:0]] <= {entry_hi[31:13], entry_hi[7:0], mask[24:13],
                                          entry_lo0[0] & entry_lo1[0],
                                          entry_lo0[25:1], entry_lo1[25:1]};
        end
    end

    assign tlb_entry = entries[index[IDX_W-1:0]];

    tlb_match_port #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_inst_match (
        .entries (entries),
        .vaddr   (inst_vaddr),
        .asid    (entry_hi[7:0]),
        .wr      (1'b0),
        .hit     (i_hit),
        .idx     (unused_inst_idx),
        .paddr   (i_paddr),
        .v       (i_v),
        .d       (unused_inst_d),
        .mod     (unused_inst_mod)
    );

    tlb_match_port #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_data_match (
        .entries (entries),
        .vaddr   (data_vaddr),
        .asid    (entry_hi[7:0]),
        .wr      (data_wr),
        .hit     (d_hit),
        .idx     (unused_data_idx),
        .paddr   (d_paddr),
        .v       (d_v),
        .d       (unused_data_d),
        .mod     (d_mod)
    );

    tlb_match_port #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_probe_match (
        .entries (entries),
        .vaddr   ({entry_hi[31:13], 13'b0}),
        .asid    (entry_hi[7:0]),
        .wr      (1'b0),
        .hit     (p_hit),
        .idx     (p_idx),
        .paddr   (unused_probe_paddr),
        .v       (unused_probe_v),
        .d       (unused_probe_d),
        .mod     (unused_probe_mod)
    );

    // Results hold their last value when no request arrives; only *_valid drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_valid   <= 1'b0;
            inst_paddr   <= '0;
            inst_refill  <= 1'b0;
            inst_invalid <= 1'b0;
        end else begin
            inst_valid <= inst_req;
            if (inst_req) begin
                if (inst_vaddr[31:30] == UNMAPPED_SEG) begin
                    inst_paddr   <= {3'b0, inst_vaddr[28:0]};
                    inst_refill  <= 1'b0;
                    inst_invalid <= 1'b0;
                end else begin
                    inst_paddr   <= i_paddr;
                    inst_refill  <= ~i_hit;
                    inst_invalid <= i_hit & ~i_v;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_valid   <= 1'b0;
            data_paddr   <= '0;
            data_refill  <= 1'b0;
            data_invalid <= 1'b0;
            data_mod     <= 1'b0;
        end else begin
            data_valid <= data_req;
            if (data_req) begin
                if (data_vaddr[31:30] == UNMAPPED_SEG) begin
                    data_paddr   <= {3'b0, data_vaddr[28:0]};
                    data_refill  <= 1'b0;
                    data_invalid <= 1'b0;
                    data_mod     <= 1'b0;
                end else begin
                    data_paddr   <= d_paddr;
                    data_refill  <= ~d_hit;
                    data_invalid <= d_hit & ~d_v;
                    data_mod     <= d_mod;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            probe_done  <= 1'b0;
            entry_index <= '0;
        end else begin
            probe_done <= probe_req;
            if (probe_req) begin
                entry_index <= {~p_hit, {(31 - IDX_W){1'b0}}, p_idx};
            end
        end
    end

    assign unused_bits = ^{index[31:IDX_W], entry_hi[12:8], entry_lo0[31:26],
                           entry_lo1[31:26], mask[31:25], mask[12:0]};

endmodule

// File: tb/tb_mips_tlb.sv
// Self-checking bench for mips_tlb: directed scenarios then randomized traffic against a field-level model.
module tb_mips_tlb;

    logic        clk;
    logic        resetn;
    logic        tlbw;
    logic [31:0] index;
    logic [31:0] entry_hi;
    logic [31:0] entry_lo0;
    logic [31:0] entry_lo1;
    logic [31:0] mask;
    logic [89:0] tlb_entry;
    logic        probe_req;
    logic        probe_done;
    logic [31:0] entry_index;
    logic        inst_req;
    logic [31:0] inst_vaddr;
    logic        inst_valid;
    logic [31:0] inst_paddr;
    logic        inst_refill;
    logic        inst_invalid;
    logic        data_req;
    logic [31:0] data_vaddr;
    logic        data_wr;
    logic        data_valid;
    logic [31:0] data_paddr;
    logic        data_refill;
    logic        data_invalid;
    logic        data_mod;

    int compareCount;
    int mismatchCount;

    logic [18:0] m_vpn2 [32];
    logic [7:0]  m_asid [32];
    logic [11:0] m_pm   [32];
    logic        m_g    [32];
    logic [19:0] m_pfn0 [32];
    logic [2:0]  m_c0   [32];
    logic        m_d0   [32];
    logic        m_v0   [32];
    logic [19:0] m_pfn1 [32];
    logic [2:0]  m_c1   [32];
    logic        m_d1   [32];
    logic        m_v1   [32];

    mips_tlb dut (
        .clk          (clk),
        .resetn       (resetn),
        .tlbw         (tlbw),
        .index        (index),
        .entry_hi     (entry_hi),
        .entry_lo0    (entry_lo0),
        .entry_lo1    (entry_lo1),
        .mask         (mask),
        .tlb_entry    (tlb_entry),
        .probe_req    (probe_req),
        .probe_done   (probe_done),
        .entry_index  (entry_index),
        .inst_req     (inst_req),
        .inst_vaddr   (inst_vaddr),
        .inst_valid   (inst_valid),
        .inst_paddr   (inst_paddr),
        .inst_refill  (inst_refill),
        .inst_invalid (inst_invalid),
        .data_req     (data_req),
        .data_vaddr   (data_vaddr),
        .data_wr      (data_wr),
        .data_valid   (data_valid),
        .data_paddr   (data_paddr),
        .data_refill  (data_refill),
        .data_invalid (data_invalid),
        .data_mod     (data_mod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 32; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_pm[i] = '0; m_g[i] = 1'b0;
            m_pfn0[i] = '0; m_c0[i] = '0; m_d0[i] = 1'b0; m_v0[i] = 1'b0;
            m_pfn1[i] = '0; m_c1[i] = '0; m_d1[i] = 1'b0; m_v1[i] = 1'b0;
        end
    endtask

    task automatic modelWrite();
        int i;
        i = int'(index[4:0]);
        m_vpn2[i] = entry_hi[31:13];
        m_asid[i] = entry_hi[7:0];
        m_pm[i]   = mask[24:13];
        m_g[i]    = entry_lo0[0] & entry_lo1[0];
        m_pfn0[i] = entry_lo0[25:6]; m_c0[i] = entry_lo0[5:3];
        m_d0[i]   = entry_lo0[2];    m_v0[i] = entry_lo0[1];
        m_pfn1[i] = entry_lo1[25:6]; m_c1[i] = entry_lo1[5:3];
        m_d1[i]   = entry_lo1[2];    m_v1[i] = entry_lo1[1];
    endtask

    function automatic logic [89:0] modelEntry(input int i);
        return {m_vpn2[i], m_asid[i], m_pm[i], m_g[i],
                m_pfn0[i], m_c0[i], m_d0[i], m_v0[i],
                m_pfn1[i], m_c1[i], m_d1[i], m_v1[i]};
    endfunction

    // A legal mask is a contiguous run of an even number of low ones.
    function automatic int pageShift(input logic [11:0] pm);
        int k;
        k = $countones(pm);
        if ((k % 2 == 0) && (int'(pm) == (1 << k) - 1)) return k;
        return 0;
    endfunction

    function automatic int findEntry(input logic [18:0] vpn2, input logic [7:0] asid);
        int k;
        for (int i = 0; i < 32; i++) begin
            k = pageShift(m_pm[i]);
            if (((m_vpn2[i] >> k) == (vpn2 >> k)) && (m_g[i] || (m_asid[i] == asid))) return i;
        end
        return -1;
    endfunction

    function automatic void predictTranslate(input logic [31:0] va, input logic [7:0] asid, input logic wr,
                                             output logic refill, output logic invalid, output logic modf,
                                             output logic [31:0] pa, output logic paKnown);
        int hitIdx;
        int k;
        logic odd;
        logic [19:0] pfn;
        logic v;
        logic d;
        logic [31:0] passMask;
        refill = 1'b0; invalid = 1'b0; modf = 1'b0; pa = '0; paKnown = 1'b1;
        if (va[31:30] == 2'b10) begin
            pa = va & 32'h1FFF_FFFF;
            return;
        end
        hitIdx = findEntry(va[31:13], asid);
        if (hitIdx < 0) begin
            refill = 1'b1;
            return;
        end
        k = pageShift(m_pm[hitIdx]);
        odd = va[12 + k];
        pfn = odd ? m_pfn1[hitIdx] : m_pfn0[hitIdx];
        v   = odd ? m_v1[hitIdx]   : m_v0[hitIdx];
        d   = odd ? m_d1[hitIdx]   : m_d0[hitIdx];
        passMask = (32'd1 << (12 + k)) - 32'd1;
        pa = ({pfn, 12'h000} & ~passMask) | (va & passMask);
        invalid = !v;
        modf = v && !d && wr;
        paKnown = v;
    endfunction

    task automatic clearInputs();
        tlbw = 1'b0; index = '0; entry_hi = '0; entry_lo0 = '0; entry_lo1 = '0; mask = '0;
        probe_req = 1'b0; inst_req = 1'b0; inst_vaddr = '0;
        data_req = 1'b0; data_vaddr = '0; data_wr = 1'b0;
    endtask

    // Predict from pre-edge state, clock once, then check everything the DUT produced.
    task automatic applyStimulus();
        logic iReq, dReq, pReq;
        logic iRef, iInv, iMod, iKnown;
        logic dRef, dInv, dMod, dKnown;
        logic [31:0] iPa, dPa, expIndex;
        int p;
        iReq = inst_req; dReq = data_req; pReq = probe_req;
        iRef = 0; iInv = 0; iMod = 0; iKnown = 0; iPa = '0;
        dRef = 0; dInv = 0; dMod = 0; dKnown = 0; dPa = '0;
        expIndex = '0;
        if (iReq) predictTranslate(inst_vaddr, entry_hi[7:0], 1'b0, iRef, iInv, iMod, iPa, iKnown);
        if (dReq) predictTranslate(data_vaddr, entry_hi[7:0], data_wr, dRef, dInv, dMod, dPa, dKnown);
        if (pReq) begin
            p = findEntry(entry_hi[31:13], entry_hi[7:0]);
            expIndex = (p < 0) ? 32'h8000_0000 : 32'(p);
        end
        if (tlbw) modelWrite();
        @(posedge clk);
        #1;
        checkOutput("inst_valid", inst_valid, iReq);
        if (iReq) begin
            checkOutput("inst_refill", inst_refill, iRef);
            checkOutput("inst_invalid", inst_invalid, iInv);
            if (iKnown) checkOutput("inst_paddr", inst_paddr, iPa);
        end
        checkOutput("data_valid", data_valid, dReq);
        if (dReq) begin
            checkOutput("data_refill", data_refill, dRef);
            checkOutput("data_invalid", data_invalid, dInv);
            checkOutput("data_mod", data_mod, dMod);
            if (dKnown) checkOutput("data_paddr", data_paddr, dPa);
        end
        checkOutput("probe_done", probe_done, pReq);
        if (pReq) checkOutput("entry_index", entry_index, expIndex);
        checkOutput("tlb_entry", tlb_entry, modelEntry(int'(index[4:0])));
    endtask

    task automatic writeEntry(input logic [4:0] idx, input logic [31:0] hi, input logic [31:0] lo0,
                              input logic [31:0] lo1, input logic [11:0] pm);
        tlbw = 1'b1; index = {27'b0, idx}; entry_hi = hi;
        entry_lo0 = lo0; entry_lo1 = lo1; mask = {7'b0, pm, 13'b0};
        applyStimulus();
        tlbw = 1'b0;
    endtask

    function automatic logic [18:0] pickVpn2();
        case ($urandom_range(0, 5))
            0: return 19'h00200;
            1: return 19'h00201;
            2: return 19'h00300;
            3: return 19'h00800;
            4: return 19'h7FFFE;
            default: return 19'($urandom);
        endcase
    endfunction

    function automatic logic [11:0] pickPm();
        case ($urandom_range(0, 8))
            0: return 12'h000;
            1: return 12'h003;
            2: return 12'h00F;
            3: return 12'h03F;
            4: return 12'h0FF;
            5: return 12'h3FF;
            6: return 12'hFFF;
            default: return 12'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pickVa();
        if ($urandom_range(0, 5) == 0) return {2'b10, 30'($urandom)};
        return {pickVpn2(), 13'($urandom)};
    endfunction

    initial begin
        compareCount = 0;
        mismatchCount = 0;
        resetn = 1'b0;
        clearInputs();
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_inst_valid", inst_valid, 1'b0);
        checkOutput("rst_data_valid", data_valid, 1'b0);
        checkOutput("rst_probe_done", probe_done, 1'b0);
        checkOutput("rst_entry_index", entry_index, 32'h0);
        checkOutput("rst_paddrs", {inst_paddr, data_paddr}, 64'h0);
        checkOutput("rst_flags", {inst_refill, inst_invalid, data_refill, data_invalid, data_mod}, 5'b0);
        checkOutput("rst_tlb_entry", tlb_entry, 90'h0);
        resetn = 1'b1;

        inst_req = 1'b1; inst_vaddr = 32'h0040_0000;
        applyStimulus();
        checkOutput("plan_inst_refill", {inst_valid, inst_refill, inst_paddr}, {2'b11, 32'h0});
        clearInputs();

        writeEntry(5'd3, 32'h0040_0005, 32'h0000_1017, 32'h0000_1801, 12'h000);
        checkOutput("plan_tlb_entry3", tlb_entry, modelEntry(3));
        clearInputs();

        data_req = 1'b1; data_vaddr = 32'h0040_0abc;
        applyStimulus();
        checkOutput("plan_data_hit", {data_paddr, data_refill, data_invalid, data_mod}, {32'h0004_0abc, 3'b000});
        data_vaddr = 32'h0040_1abc;
        applyStimulus();
        checkOutput("plan_data_invalid", data_invalid, 1'b1);
        clearInputs();

        writeEntry(5'd7, 32'h0060_0005, 32'h0000_1402, 32'h0000_1402, 12'h000);
        entry_hi = 32'h0060_0005; data_req = 1'b1; data_wr = 1'b1; data_vaddr = 32'h0060_0123;
        applyStimulus();
        checkOutput("plan_data_mod", {data_mod, data_paddr}, {1'b1, 32'h0005_0123});
        entry_hi = 32'h0060_0006;
        applyStimulus();
        checkOutput("plan_asid_refill", {data_refill, data_mod}, 2'b10);
        clearInputs();

        probe_req = 1'b1; entry_hi = 32'h0040_0009;
        applyStimulus();
        checkOutput("plan_probe_hit", {probe_done, entry_index}, {1'b1, 32'h0000_0003});
        entry_hi = 32'hFFFF_C000;
        applyStimulus();
        checkOutput("plan_probe_miss", {probe_done, entry_index}, {1'b1, 32'h8000_0000});
        clearInputs();

        writeEntry(5'd10, 32'h0100_0000, 32'h0004_0007, 32'h0004_0007, 12'hFFF);
        inst_req = 1'b1; inst_vaddr = 32'h0101_2345;
        applyStimulus();
        checkOutput("plan_pm_fff", inst_paddr, 32'h0101_2345);
        tlbw = 1'b1; index = 32'd10; entry_hi = 32'h0100_0000;
        entry_lo0 = 32'h0008_0007; entry_lo1 = 32'h0008_0007; mask = 32'h01FF_E000;
        applyStimulus();
        checkOutput("plan_same_edge_old", inst_paddr, 32'h0101_2345);
        tlbw = 1'b0;
        applyStimulus();
        checkOutput("plan_after_write_new", inst_paddr, 32'h0201_2345);
        inst_vaddr = 32'hA000_1234;
        applyStimulus();
        checkOutput("plan_kseg", {inst_paddr, inst_refill, inst_invalid}, {32'h0000_1234, 2'b00});
        clearInputs();

        probe_req = 1'b1; inst_req = 1'b1; inst_vaddr = 32'h0040_0000; entry_hi = 32'h0040_0009;
        #2;
        resetn = 1'b0;
        resetModel();
        @(posedge clk);
        #1;
        checkOutput("midreset_probe", {probe_done, entry_index}, 33'h0);
        checkOutput("midreset_inst_valid", inst_valid, 1'b0);
        checkOutput("midreset_tlb_entry", tlb_entry, 90'h0);
        resetn = 1'b1;
        clearInputs();
        applyStimulus();

        for (int n = 0; n < 400; n++) begin
            tlbw       = ($urandom_range(0, 3) == 0);
            index      = $urandom;
            entry_hi   = {pickVpn2(), 5'($urandom), 8'($urandom_range(5, 6))};
            entry_lo0  = $urandom;
            entry_lo1  = $urandom;
            mask       = {7'($urandom), pickPm(), 13'($urandom)};
            probe_req  = ($urandom_range(0, 2) != 0);
            inst_req   = ($urandom_range(0, 2) != 0);
            inst_vaddr = pickVa();
            data_req   = ($urandom_range(0, 2) != 0);
            data_vaddr = pickVa();
            data_wr    = 1'($urandom);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
